// File: rtl/morph_pass_sequencer.sv
// Multi-pass binary morphology sequencer: drives the row filter and ping-pongs the two frame banks.
// Optional feature: define LIVE_VIEW_EN to show every intermediate pass on the VGA scanout.
module morph_pass_sequencer #(
    parameter int PASS_CYCLES = 52,
    parameter int REPS_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go_i,
    input  logic              abort_i,
    input  logic [1:0]        op_mode_i,
    input  logic [REPS_W-1:0] reps_i,
    input  logic              kernel_sel_i,
    output logic              flt_start_o,
    output logic              flt_operator_o,
    output logic              flt_kernel_o,
    output logic              src_bank_o,
    output logic              dst_bank_o,
    output logic              disp_bank_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [REPS_W:0]   pass_idx_o
);

    localparam int CNT_W = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PASS_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        SWAP,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic              kernel_q, kernel_d;
    logic [REPS_W:0]   reps_eff_q, reps_eff_d;
    logic [REPS_W:0]   total_q, total_d;
    logic [REPS_W:0]   pass_idx_q, pass_idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_q, op_d;
    logic              src_q, src_d;
    logic              disp_q, disp_d;
    logic              flt_start;
    logic              done;

    logic [REPS_W:0]   reps_in_eff;
    logic [REPS_W:0]   total_in;

    // A zero repetition count still runs one pass; open/close need two phases.
    assign reps_in_eff = (reps_i == '0) ? (REPS_W+1)'(1) : {1'b0, reps_i};
    assign total_in    = op_mode_i[1] ? {reps_in_eff[REPS_W-1:0], 1'b0} : reps_in_eff;

    // Open is erode then dilate, close is dilate then erode; the phase flips once idx reaches reps.
    function automatic logic op_select(input logic [1:0]      mode,
                                       input logic [REPS_W:0] idx,
                                       input logic [REPS_W:0] reps_eff);
        logic first_phase;
        first_phase = (idx < reps_eff);
        case (mode)
            2'b00:   op_select = 1'b1;
            2'b01:   op_select = 1'b0;
            2'b10:   op_select = first_phase;
            default: op_select = ~first_phase;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mode_q     <= 2'b00;
            kernel_q   <= 1'b0;
            reps_eff_q <= '0;
            total_q    <= '0;
            pass_idx_q <= '0;
            cnt_q      <= '0;
            op_q       <= 1'b0;
            src_q      <= 1'b0;
            disp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            kernel_q   <= kernel_d;
            reps_eff_q <= reps_eff_d;
            total_q    <= total_d;
            pass_idx_q <= pass_idx_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            src_q      <= src_d;
            disp_q     <= disp_d;
        end
    end

    // Abort takes precedence in every busy state and leaves both banks untouched.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        kernel_d   = kernel_q;
        reps_eff_d = reps_eff_q;
        total_d    = total_q;
        pass_idx_d = pass_idx_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        src_d      = src_q;
        disp_d     = disp_q;
        flt_start  = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (go_i) begin
                    mode_d     = op_mode_i;
                    kernel_d   = kernel_sel_i;
                    reps_eff_d = reps_in_eff;
                    total_d    = total_in;
                    pass_idx_d = '0;
                    op_d       = op_select(op_mode_i, '0, reps_in_eff);
                    state_d    = START;
                end
            end
            START: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    flt_start = 1'b1;
                    cnt_d     = CNT_LOAD;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = SWAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SWAP: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    src_d = ~src_q;
`ifdef LIVE_VIEW_EN
                    disp_d = ~src_q;
`endif
                    if (pass_idx_q == total_q - 1'b1) begin
                        state_d = DONE;
                    end else begin
                        pass_idx_d = pass_idx_q + 1'b1;
                        op_d       = op_select(mode_q, pass_idx_q + 1'b1, reps_eff_q);
                        state_d    = START;
                    end
                end
            end
            DONE: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    done = 1'b1;
`ifndef LIVE_VIEW_EN
                    disp_d = src_q;
`endif
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign flt_start_o    = flt_start;
    assign done_o         = done;
    assign flt_operator_o = op_q;
    assign flt_kernel_o   = kernel_q;
    assign src_bank_o     = src_q;
    assign dst_bank_o     = ~src_q;
    assign disp_bank_o    = disp_q;
    assign busy_o         = (state_q != IDLE);
    assign pass_idx_o     = pass_idx_q;

endmodule

// File: doc/morph_pass_sequencer.md
Name: morph_pass_sequencer

Overview:
- Sequences multi-pass binary morphology (erode, dilate, open, close) on the 64x50 bitmap frame by driving the row filter's start pulse and operator/kernel selects.
- Ping-pongs two frame banks (A=0, B=1): filter reads the source bank and writes the destination bank; banks swap after each pass.
- Sits between the switch/button front end and the filter plus frame RAM muxes.
- Tells the VGA scanout which bank holds the finished image.

Parameters:
- PASS_CYCLES, 52, clocks the filter needs from start pulse to write-back complete (50 rows plus pipeline margin).
- REPS_W, 3, width of the repetition count input.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- go  in  1  start request, level; sampled only in IDLE
- abort  in  1  synchronous abort, highest priority outside IDLE
- op_mode  in  2  00 erode, 01 dilate, 10 open, 11 close
- reps  in  REPS_W  passes per phase; 0 is treated as 1
- kernel_sel  in  1  1 = 5-point cross kernel, 0 = 4-point (centre excluded)
- flt_start  out  1  one-cycle start pulse to the filter (its reset_enable)
- flt_operator  out  1  1 = AND (erode), 0 = OR (dilate)
- flt_kernel  out  1  latched kernel_sel
- src_bank  out  1  bank routed to the filter read port
- dst_bank  out  1  bank routed to the filter write port; always ~src_bank
- disp_bank  out  1  bank the VGA scanout reads
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the sequence completes
- pass_idx  out  REPS_W+1  index of the current pass, zero-based

Behaviour:
- Reset values: state IDLE, flt_start 0, flt_operator 0, flt_kernel 0, src_bank 0, disp_bank 0, busy 0, done 0, pass_idx 0.
- States: IDLE, START, RUN, SWAP, DONE.
- IDLE, go=1: latch op_mode, kernel_sel and reps_eff = (reps==0 ? 1 : reps); total = reps_eff for modes 00/01, 2*reps_eff for 10/11; pass_idx <= 0; go to START.
- START (1 cycle): flt_start=1; load cycle counter with PASS_CYCLES-1; go to RUN.
- RUN: decrement the counter each cycle; when it reaches 0, go to SWAP. RUN therefore lasts exactly PASS_CYCLES cycles.
- SWAP (1 cycle): src_bank <= dst_bank.
  - If pass_idx == total-1: go to DONE.
  - Otherwise: pass_idx++ and go to START.
- DONE (1 cycle): done=1; disp_bank <= src_bank (the last written bank); go to IDLE.
- Per-pass cost is PASS_CYCLES+2 cycles. With go sampled at edge 0, the first flt_start is high in cycle 1 and done is high in cycle total*(PASS_CYCLES+2)+1.
- flt_operator is registered and updated on entry to START:
  - erode: 1; dilate: 0.
  - open: 1 while pass_idx < reps_eff, otherwise 0.
  - close: 0 while pass_idx < reps_eff, otherwise 1.
- flt_operator and flt_kernel are held stable for the whole of RUN.
- go held high through DONE retriggers on the next IDLE cycle. go while busy is ignored. Input changes while busy are ignored because all inputs are latched.
- abort in START/RUN/SWAP/DONE: next state IDLE; flt_start 0; done not pulsed; disp_bank unchanged; src_bank keeps its current value.
- abort wins over a simultaneous SWAP→DONE transition.
- Asynchronous reset mid-sequence forces all reset values immediately.

Optional Feature:
- Macro LIVE_VIEW_EN.
- Defined: disp_bank <= dst_bank in every SWAP, so intermediate passes appear on screen; DONE does not update it again.
- Undefined: disp_bank changes only in DONE, so only final results are displayed.

Test Plan:
- Reset with go=0 -> all outputs 0, busy 0, state stays IDLE for 100 cycles.
- op_mode=00, reps=1, kernel_sel=1, go pulse -> single flt_start one cycle after go; flt_operator=1, flt_kernel=1; done 55 cycles after go; src_bank and disp_bank both 1.
- op_mode=10, reps=2 -> 4 flt_start pulses spaced 54 cycles apart; flt_operator sequence 1,1,0,0; pass_idx 0..3; final disp_bank 0.
- op_mode=11, reps=0 -> treated as reps=1; 2 passes with flt_operator 0 then 1; done at cycle 109.
- abort asserted in cycle 30 of the second pass of a close -> IDLE next cycle, no done, disp_bank keeps its previous value; a following go restarts with pass_idx 0.
- LIVE_VIEW_EN defined, op_mode=01, reps=3 -> disp_bank toggles 1,0,1 at each SWAP; done coincides with no further change.
